// File: rtl/seg_timer_display.sv
// seg_timer_display: BCD MM:SS round timer multiplexed onto a 4-digit common-anode display.
// Optional pause blink (display dark on alternate seconds while paused or done) under SEG_PAUSE_BLINK_EN.
module seg_timer_display #(
    parameter int MAX_MIN     = 59,
    parameter int SCAN_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_tick,
    input  logic       sec_tick,
    input  logic       run,
    input  logic       clear,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       done
);
    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
    logic       done_q, done_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       step, at_max, adv, wrap_so, wrap_st, wrap_mo, blank;
    logic [3:0] digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

`ifdef SEG_PAUSE_BLINK_EN
    logic phase_q;
    always_ff @(posedge clk) begin
        if (rst || clear || (run && !done_q))
            phase_q <= 1'b0;
        else if (sec_tick && (done_q || |{sec_ones_q, sec_tens_q, min_ones_q, min_tens_q}))
            phase_q <= ~phase_q;
    end
    assign blank = phase_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        step    = run && sec_tick && !done_q;
        at_max  = min_tens_q == MAX_TENS && min_ones_q == MAX_ONES && sec_tens_q == 4'd5 && sec_ones_q == 4'd9;
        adv     = step && !at_max;
        wrap_so = sec_ones_q == 4'd9;
        wrap_st = wrap_so && sec_tens_q == 4'd5;
        wrap_mo = wrap_st && min_ones_q == 4'd9;
        sec_ones_d = clear ? 4'd0 : adv ? (wrap_so ? 4'd0 : sec_ones_q + 4'd1) : sec_ones_q;
        sec_tens_d = clear ? 4'd0 : (adv && wrap_so) ? (wrap_st ? 4'd0 : sec_tens_q + 4'd1) : sec_tens_q;
        min_ones_d = clear ? 4'd0 : (adv && wrap_st) ? (wrap_mo ? 4'd0 : min_ones_q + 4'd1) : min_ones_q;
        min_tens_d = clear ? 4'd0 : (adv && wrap_mo) ? min_tens_q + 4'd1 : min_tens_q;
        done_d     = clear ? 1'b0 : (step && at_max) ? 1'b1 : done_q;
        // Display samples the pre-edge timer; a same-cycle increment shows on a later scan.
        digit = idx_q == 2'd0 ? sec_ones_q : idx_q == 2'd1 ? sec_tens_q : idx_q == 2'd2 ? min_ones_q : min_tens_q;
        idx_d = seg_tick ? idx_q + 2'd1 : idx_q;
        an_d  = !seg_tick ? an_q : blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = seg_tick ? seg_code(digit) : seg_q;
        dp_d  = seg_tick ? idx_q != 2'd2 : dp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            done_q     <= 1'b0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) $countones(~an_q) <= 1 && SCAN_DIGITS == $bits(an_q));

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign done = done_q;
endmodule

// File: tb/tb_seg_timer_display.sv
// tb_seg_timer_display: scoreboarded random + directed bench against a seconds-count reference model.
module tb_seg_timer_display;
    localparam int MAXM  = 1;
    localparam int LIMIT = MAXM * 60 + 59;

    logic       clk = 0, rst = 1, seg_tick = 0, sec_tick = 0, run = 0, clear = 0;
    logic [6:0] seg;
    logic       dp, done;
    logic [3:0] an;

    seg_timer_display #(.MAX_MIN(MAXM), .SCAN_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .seg_tick(seg_tick), .sec_tick(sec_tick),
        .run(run), .clear(clear), .seg(seg), .dp(dp), .an(an), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       done;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    int t = 0, k = 0;
    bit m_done = 0;
    logic [3:0] m_an = 4'b1111;
    logic [6:0] m_seg = 7'b1111111;
    logic       m_dp = 1'b1;
    logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic int digit_of(input int tt, input int kk);
        int s, m;
        s = tt % 60;
        m = tt / 60;
        case (kk)
            0: return s % 10;
            1: return s / 10;
            2: return m % 10;
            default: return m / 10;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1; seg_tick = 0; sec_tick = 0; run = 0; clear = 0;
        t = 0; k = 0; m_done = 0; m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
        q.push_back({m_an, m_seg, m_dp, m_done});
    endtask

    task automatic cyc(input bit st, input bit sc, input bit r, input bit c);
        @(negedge clk); #1;
        rst = 0; seg_tick = st; sec_tick = sc; run = r; clear = c;
        if (st) begin
            m_an  = an_tab[k];
            m_seg = codes[digit_of(t, k)];
            m_dp  = (k == 2) ? 1'b0 : 1'b1;
            k     = (k + 1) % 4;
        end
        if (c) begin
            t = 0;
            m_done = 0;
        end else if (r && sc && !m_done) begin
            if (t == LIMIT) m_done = 1;
            else t++;
        end
        q.push_back({m_an, m_seg, m_dp, m_done});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, dp, done} !== e) begin
                failures++;
                $display("FAIL outputs @%0t: got an=%b seg=%b dp=%b done=%b, want an=%b seg=%b dp=%b done=%b",
                         $time, an, seg, dp, done, e.an, e.seg, e.dp, e.done);
            end
        end
    end

    initial begin
        bit r;
        do_reset();
        do_reset();
        repeat (3) cyc(0, 0, 0, 0);
        repeat (4) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        repeat (75) cyc(0, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 0);
        repeat (44) cyc(0, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 0);
        repeat (11) cyc(0, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        repeat (42) cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 1);
        repeat (5) cyc(0, 1, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (9) cyc(0, 1, 1, 0);
        while (k != 0) cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 0);
        r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, r, $urandom_range(0, 199) == 0);
        end
        cyc(0, 0, 0, 0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected records left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_timer_display.md
Name: seg_timer_display

Overview:
- Consumes the periodic single-cycle enable strobes from the game clock divider: the ~300 Hz scan tick and the 1 Hz seconds tick.
- Keeps a BCD MM:SS round timer for Light-Cycles.
- Time-multiplexes the timer onto the board's 4-digit common-anode seven-segment display.
- Sits between the clock divider and the top-level display pins; the game FSM drives run/clear and reads done.

Parameters:
- MAX_MIN, 59, highest minutes value (decimal, 0-99); the timer saturates at MAX_MIN:59.
- SCAN_DIGITS, 4, number of digits scanned (fixed at 4; the parameter exists for assertion checks only).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- seg_tick  input  1  one-cycle scan enable, ~300 Hz.
- sec_tick  input  1  one-cycle seconds enable, 1 Hz.
- run  input  1  level; timer counts while high.
- clear  input  1  one-cycle; zeroes the timer and done.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- done  output  1  sticky; high once the timer reaches MAX_MIN:59.

Behaviour:
- Reset (synchronous, on clk edge with rst=1): timer=00:00, digit index=0, done=0, an=4'b1111, seg=7'b1111111, dp=1. All digits stay dark until the first seg_tick.
- Timer registers: sec_ones, sec_tens, min_ones, min_tens, each 4-bit BCD.
- Timer priority per cycle: clear > (run & sec_tick & !done) > hold.
- Increment rules:
  - sec_ones 9->0 carries to sec_tens.
  - sec_tens 5->0 (at :59) carries to minutes.
  - min_ones 9->0 carries to min_tens.
- Saturation: when the pre-increment value is MAX_MIN:59, the timer holds and done<=1 on that edge. Further sec_ticks are ignored until clear.
- clear concurrent with sec_tick: result is 00:00 and done=0; the tick is lost.
- run=0: sec_tick ignored. run may toggle at any cycle.
- Scan sequencing:
  - On seg_tick, digit index <= (index+1) mod 4. The first tick after reset selects index 0.
  - an, seg and dp are registered and update on the same edge as the index; 1-cycle latency from seg_tick.
  - Exactly one an bit is low after the first seg_tick.
- Digit map:
  - index 0 = sec_ones
  - index 1 = sec_tens
  - index 2 = min_ones, with dp=0 (colon substitute)
  - index 3 = min_tens
  - dp=1 on all other digits.
- Sampling: the digit value is taken from the timer registers as they stand before the current edge. A same-cycle sec_tick increment is displayed on a later scan.
- Segment codes (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10-15 = 1111111 (blank)
- Between seg_ticks, outputs hold their values.
- done is registered, cleared only by rst or clear.

Optional Feature:
- Macro SEG_PAUSE_BLINK_EN.
- Defined:
  - A blink-phase flop toggles on every sec_tick while run=0 and the timer is nonzero.
  - The flop is forced to 0 by rst, clear, or run=1.
  - While phase=1, the next scan update drives an=4'b1111 (display dark), giving a 1 Hz pause blink. Index sequencing continues.
  - done=1 also forces blinking regardless of run.
- Not defined: no phase flop; the display is never blanked after the first seg_tick.

Test Plan:
- Reset then 4 seg_ticks with the timer at 00:00 -> an sequence 1110, 1101, 1011, 0111; seg=1000000 each; dp=0 only when an=1011; all outputs dark before the first tick.
- run=1, 75 sec_ticks -> timer 01:15; scanning shows seg 0010010 (5), 1111001 (1), 1111001 (1) with dp=0, then 1000000 (0).
- MAX_MIN=1, run=1, 119 sec_ticks -> 01:59 with done=0; 120th tick -> still 01:59, done=1; 10 more ticks change nothing.
- clear asserted in the same cycle as sec_tick at 00:42 -> next cycle timer=00:00, done=0; run=0 with 5 sec_ticks -> still 00:00.
- seg_tick and sec_tick in the same cycle with index advancing to 0 at 00:09 -> that scan shows seg=0010000 (9); the next scan of index 0 shows 1000000 with the timer at 00:10.
- SEG_PAUSE_BLINK_EN defined, timer 00:03, run=0, 2 sec_ticks with scanning -> an=1111 after the first tick, scanning resumes after the second; run=1 -> blinking stops at once.
